// File: rtl/switch_debounce_4.sv
// switch_debounce_4: synchronises and debounces four raw board switches.
// Each switch feeds the lab function blocks as a clean level on inA..inD.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   sw[3:0]  raw switches (sw[3]->inA, sw[2]->inB, sw[1]->inC, sw[0]->inD)
//   inA..inD debounced switch levels
//   valid    high once the startup window has completed, until reset
//   changed  one-cycle pulse when any debounced output takes a new value
module switch_debounce_4 #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 2)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output logic       inA,
  output logic       inB,
  output logic       inC,
  output logic       inD,
  output logic       valid,
  output logic       changed
);

  localparam int unsigned NUM_SW = 4;
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } stateE;

  stateE             state;
  stateE             stateNext;
  logic [NUM_SW-1:0] sync1;
  logic [NUM_SW-1:0] sync2;
  logic [CNT_W-1:0]  startCnt;
  logic [CNT_W-1:0]  startCntNext;
  logic [CNT_W-1:0]  bitCnt     [NUM_SW];
  logic [CNT_W-1:0]  bitCntNext [NUM_SW];
  logic [NUM_SW-1:0] outQ;
  logic [NUM_SW-1:0] outNext;
  logic              validNext;
  logic              changedNext;

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      startCnt <= '0;
      outQ     <= '0;
      valid    <= 1'b0;
      changed  <= 1'b0;
      for (int i = 0; i < int'(NUM_SW); i++) begin
        bitCnt[i] <= '0;
      end
    end else begin
      state    <= stateNext;
      startCnt <= startCntNext;
      outQ     <= outNext;
      valid    <= validNext;
      changed  <= changedNext;
      for (int i = 0; i < int'(NUM_SW); i++) begin
        bitCnt[i] <= bitCntNext[i];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext    = state;
    startCntNext = startCnt;
    outNext      = outQ;
    validNext    = valid;
    changedNext  = 1'b0;
    for (int i = 0; i < int'(NUM_SW); i++) begin
      bitCntNext[i] = bitCnt[i];
    end

    case (state)
      INIT: begin
        // Wait out the synchroniser fill plus one debounce window, then
        // adopt the synchronised levels directly without a changed pulse.
        if (startCnt == START_LAST) begin
          outNext   = sync2;
          validNext = 1'b1;
          stateNext = RUN;
          for (int i = 0; i < int'(NUM_SW); i++) begin
            bitCntNext[i] = '0;
          end
        end else begin
          startCntNext = startCnt + CNT_W'(1);
        end
      end

      RUN: begin
        // Independent per-bit counters; any bounce back restarts the count.
        for (int i = 0; i < int'(NUM_SW); i++) begin
          if (sync2[i] == outQ[i]) begin
            bitCntNext[i] = '0;
          end else if (bitCnt[i] == CNT_LAST) begin
            outNext[i]    = sync2[i];
            bitCntNext[i] = '0;
          end else begin
            bitCntNext[i] = bitCnt[i] + CNT_W'(1);
          end
        end
        changedNext = |(outNext ^ outQ);
      end

      default: begin
        stateNext = INIT;
      end
    endcase
  end

  assign inA = outQ[3];
  assign inB = outQ[2];
  assign inC = outQ[1];
  assign inD = outQ[0];

endmodule

// File: tb/tb_switch_debounce_4.sv
// Scoreboard bench for switch_debounce_4 with DEBOUNCE_CYCLES = 4.
// Stimulus pushes the expected debounced level and update cycle for every
// accepted switch change; a monitor pops one entry per changed pulse.
module tb_switch_debounce_4;

  localparam int LAT = 6; // 2 sync stages + 4 debounce cycles, counted from drive

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       inA, inB, inC, inD;
  logic       valid;
  logic       changed;

  always #5 clk = ~clk;

  switch_debounce_4 #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .inA     (inA),
    .inB     (inB),
    .inC     (inC),
    .inD     (inD),
    .valid   (valid),
    .changed (changed)
  );

  typedef struct {
    logic [3:0] val;
    logic       yExp;
    int         cyc;
  } expT;

  expT        expQ[$];
  int         checks     = 0;
  int         failures   = 0;
  int         cyc        = 0;
  int         unexpected = 0;
  logic [3:0] held       = 4'b0000;
  // Hand-computed truth table of Y = B | (~C & D) | (A & D), indexed by {A,B,C,D}
  logic [15:0] yTable    = 16'hFAF2;

  logic [3:0] outs;
  logic       yDut;
  assign outs = {inA, inB, inC, inD};
  assign yDut = inB | (~inC & inD) | (inA & inD);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOuts(input string name, input logic [3:0] expOut, input logic expValid);
    check({name, "_outs"}, 32'(outs), 32'(expOut));
    check({name, "_valid"}, 32'(valid), 32'(expValid));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Drive a new level and, if it differs from the debounced state, expect it later
  task automatic applySw(input logic [3:0] v);
    expT e;
    sw = v;
    if (v != held) begin
      e.val  = v;
      e.yExp = yTable[v];
      e.cyc  = cyc + LAT;
      expQ.push_back(e);
      held = v;
    end
  endtask

  // Monitor: every changed pulse must match the next scoreboard entry
  always @(negedge clk) begin
    expT e;
    if (rst_n === 1'b1 && changed === 1'b1) begin
      if (expQ.size() == 0) begin
        unexpected++;
        $display("FAIL unexpected_changed outs=%b cycle=%0d", outs, cyc);
      end else begin
        e = expQ.pop_front();
        check("changed_cycle", 32'(cyc), 32'(e.cyc));
        check("changed_outs", 32'(outs), 32'(e.val));
        check("changed_y", 32'(yDut), 32'(e.yExp));
      end
    end
  end

  initial begin
    // Reset and startup window
    rst_n = 1'b0;
    sw    = 4'b1010;
    step(3);
    checkOuts("reset", 4'b0000, 1'b0);
    check("reset_changed", 32'(changed), 32'(1'b0));
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      checkOuts("init_wait", 4'b0000, 1'b0);
    end
    step(1);
    checkOuts("init_load", 4'b1010, 1'b1);
    held = 4'b1010;

    // Clean change
    applySw(4'b0000);
    step(8);
    applySw(4'b1000);
    step(5);
    check("clean_before", 32'(inA), 32'(1'b0));
    step(3);
    checkOuts("clean_after", 4'b1000, 1'b1);

    // Bounce rejection: short pulses on sw[0] ending low
    sw = 4'b1001; step(2);
    sw = 4'b1000; step(2);
    sw = 4'b1001; step(2);
    sw = 4'b1000; step(10);
    checkOuts("bounce_low", 4'b1000, 1'b1);

    // Bounce ending high and held
    sw = 4'b1001; step(2);
    sw = 4'b1000; step(2);
    applySw(4'b1001);
    step(8);
    checkOuts("bounce_high", 4'b1001, 1'b1);

    // Simultaneous change, then staggered by one cycle
    applySw(4'b0000); step(8);
    applySw(4'b0110); step(8);
    checkOuts("simul", 4'b0110, 1'b1);
    applySw(4'b0000); step(8);
    applySw(4'b0100); step(1);
    applySw(4'b0110); step(8);
    checkOuts("stagger", 4'b0110, 1'b1);

    // Reset mid-count
    applySw(4'b0000); step(8);
    sw = 4'b0010;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOuts("async_reset", 4'b0000, 1'b0);
    step(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      checkOuts("reinit_wait", 4'b0000, 1'b0);
    end
    step(1);
    checkOuts("reinit_load", 4'b0010, 1'b1);
    held = 4'b0010;

    // Downstream integration sweep
    for (int c = 0; c < 16; c++) begin
      applySw(4'(c));
      step(8);
      checkOuts("sweep", 4'(c), 1'b1);
    end

    step(2);
    check("pending_expected", 32'(expQ.size()), 32'd0);
    check("unexpected_changed", 32'(unexpected), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
